// File: rtl/bramfifo_pkg.sv
// Shared types and helpers for the bramfifo write-side arbiter.
package bramfifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int idw(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bramfifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after last+1 (mod N_), so the
// requester at `last` is chosen only when nobody else is asking.
module rr_pick
    import bramfifo_pkg::*;
#(
    parameter int N_   = 4,
    parameter int IDW_ = idw(N_)
) (
    input  logic [N_-1:0]   req,
    input  logic [IDW_-1:0] last,
    output logic            found,
    output logic [IDW_-1:0] idx
);

    int w_j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_j   = 0;
        for (int k = 1; k <= N_; k++) begin
            w_j = int'(last) + k;
            if (w_j >= N_) w_j = w_j - N_;
            if (!found && req[w_j]) begin
                found = 1'b1;
                idx   = w_j[IDW_-1:0];
            end
        end
    end

endmodule

// File: rtl/bramfifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one bramfifo write port among N_ producers;
// each written word is tagged with its source index.
module bramfifo_wr_arbiter
    import bramfifo_pkg::*;
#(
    parameter  int N_     = 4,
    parameter  int DATA_  = 8,
    parameter  int BURST_ = 4,
    localparam int IDW_   = idw(N_)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_-1:0]         req_valid,
    input  logic [N_*DATA_-1:0]   req_data,
    output logic [N_-1:0]         req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_we,
    output logic [DATA_+IDW_-1:0] fifo_din,
    output logic [N_-1:0]         grant,
    output logic                  busy
);

    arb_state_t      r_state, w_state_nxt;
    logic [IDW_-1:0] r_owner, w_owner_nxt;
    logic [IDW_-1:0] r_last, w_last_nxt;
    logic [7:0]      r_cnt, w_cnt_nxt;

    logic            w_own_vld, w_xfer, w_burst_end, w_found;
    logic [IDW_-1:0] w_pick, w_pick_last;
    logic [N_-1:0]   w_own_oh;

    assign w_own_vld   = req_valid[r_owner];
    assign w_xfer      = (r_state == GRANT) && w_own_vld && !fifo_full;
    assign w_burst_end = (r_state == GRANT) &&
                         ((w_xfer && (r_cnt == 8'(BURST_ - 1))) || !w_own_vld);
    // At burst end the search starts after the finishing owner, as if last were already updated.
    assign w_pick_last = w_burst_end ? r_owner : r_last;

    rr_pick #(.N_(N_), .IDW_(IDW_)) u_pick (
        .req   (req_valid),
        .last  (w_pick_last),
        .found (w_found),
        .idx   (w_pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= IDW_'(N_ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_owner_nxt = w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (w_burst_end) begin
                    w_last_nxt = r_owner;
                    w_cnt_nxt  = '0;
                    if (w_found) w_owner_nxt = w_pick;
                    else         w_state_nxt = IDLE;
                end else if (w_xfer) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_own_oh  = N_'(1) << r_owner;
    assign busy      = (r_state == GRANT);
    assign grant     = busy   ? w_own_oh : '0;
    assign req_ready = w_xfer ? w_own_oh : '0;
    assign fifo_we   = w_xfer;
    assign fifo_din  = {r_owner, req_data[int'(r_owner)*DATA_ +: DATA_]};

endmodule

// File: tb/tb_bramfifo_wr_arbiter.sv
// Directed scenarios on a 4-requester arbiter plus a randomized scoreboard run
// on a 3-requester arbiter against a behavioural model.
module tb_bramfifo_wr_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  v4, rdy4, g4;
    logic [31:0] d4;
    logic        full4, we4, busy4;
    logic [9:0]  din4;

    logic [2:0]  v3, rdy3, g3;
    logic [23:0] d3;
    logic        full3, we3, busy3;
    logic [9:0]  din3;

    bramfifo_wr_arbiter #(.N_(4), .DATA_(8), .BURST_(4)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_data(d4), .req_ready(rdy4),
        .fifo_full(full4), .fifo_we(we4), .fifo_din(din4), .grant(g4), .busy(busy4)
    );

    bramfifo_wr_arbiter #(.N_(3), .DATA_(8), .BURST_(4)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_data(d3), .req_ready(rdy3),
        .fifo_full(full3), .fifo_we(we3), .fifo_din(din3), .grant(g3), .busy(busy3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] sq4[4];
    logic [7:0] sq3[3];
    logic [7:0] sb3[3];

    task automatic drive_d4();
        for (int i = 0; i < 4; i++) d4[i*8 +: 8] = sq4[i];
    endtask

    task automatic drive_d3();
        for (int i = 0; i < 3; i++) d3[i*8 +: 8] = sq3[i];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v4 = '0; full4 = 1'b0; v3 = '0; full3 = 1'b0;
        for (int i = 0; i < 4; i++) sq4[i] = 8'(i * 64);
        drive_d4();
        d3 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic int pick3(input int last, input logic [2:0] v);
        for (int k = 1; k <= 3; k++) begin
            if (v[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    initial begin
        logic [3:0] rs;
        logic [1:0] t;
        int nw, first, last_c;
        logic [8:0] t3_we, t3_full;
        int m_own, m_last, m_cnt, run, run_src, max_run;
        logic m_we;
        logic [17:0] exp_v, obs_v;
        logic [2:0] rs3, m_oh;

        // Reset values
        rst = 1'b1; v4 = '0; d4 = '0; full4 = 1'b0; v3 = '0; d3 = '0; full3 = 1'b0;
        #1;
        chk("rst_outs4", {we4, busy4, g4, rdy4}, 0);
        chk("rst_outs3", {we3, busy3, g3, rdy3}, 0);

        // Single requester 2, 10 words, seamless re-grant
        do_reset();
        @(posedge clk); #1;
        v4 = 4'b0100;
        nw = 0; first = -1; last_c = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            rs = rdy4;
            if (we4) begin
                if (first < 0) first = c;
                last_c = c;
                chk("t1_din", din4, {2'd2, sq4[2]});
            end
            @(posedge clk); #1;
            if (rs[2]) begin
                nw++;
                sq4[2]++;
                drive_d4();
            end
            if (nw == 10) v4 = '0;
        end
        chk("t1_words", nw, 10);
        chk("t1_first", first, 1);
        chk("t1_span", last_c - first + 1, 10);

        // All four valid: 0,1,2,3,0 with 4 words each, no gaps
        do_reset();
        @(posedge clk); #1;
        v4 = 4'hf;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            rs = rdy4;
            if (c == 0) chk("t2_idle", {we4, busy4}, 0);
            else begin
                t = 2'(((c - 1) / 4) % 4);
                chk("t2_wr", {we4, g4, din4}, {1'b1, 4'(4'd1 << t), t, sq4[t]});
            end
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) if (rs[i]) sq4[i]++;
            drive_d4();
        end

        // FIFO full stall in the middle of requester 1's burst
        do_reset();
        @(posedge clk); #1;
        v4 = 4'b0010;
        t3_we   = 9'b111000110;
        t3_full = 9'b000111000;
        for (int c = 0; c <= 8; c++) begin
            full4 = t3_full[c];
            if (c == 3) v4[0] = 1'b1;
            #1;
            @(negedge clk);
            rs = rdy4;
            t = (c == 8) ? 2'd0 : 2'd1;
            chk("t3_we_rdy", {we4, rdy4}, {t3_we[c], t3_we[c] ? 4'(4'd1 << t) : 4'd0});
            chk("t3_grant", g4, (c == 0) ? 4'd0 : 4'(4'd1 << t));
            if (t3_we[c]) chk("t3_din", din4, {t, sq4[t]});
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) if (rs[i]) sq4[i]++;
            drive_d4();
        end
        full4 = 1'b0;

        // Requester 3 drops valid after 2 words while requester 0 waits
        do_reset();
        @(posedge clk); #1;
        v4 = 4'b1000;
        for (int c = 0; c <= 4; c++) begin
            if (c == 1) v4[0] = 1'b1;
            if (c == 3) v4[3] = 1'b0;
            @(negedge clk);
            rs = rdy4;
            case (c)
                0: chk("t4_c0", {we4, g4}, {1'b0, 4'b0000});
                1: chk("t4_c1", {we4, g4}, {1'b1, 4'b1000});
                2: chk("t4_c2", {we4, g4}, {1'b1, 4'b1000});
                3: chk("t4_c3", {we4, g4}, {1'b0, 4'b1000});
                default: chk("t4_c4", {we4, g4, din4[9:8]}, {1'b1, 4'b0001, 2'd0});
            endcase
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) if (rs[i]) sq4[i]++;
            drive_d4();
        end

        // Asynchronous reset mid-burst
        do_reset();
        @(posedge clk); #1;
        v4 = 4'b0100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5_busy_pre", {busy4, we4}, 2'b11);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5_async", {we4, busy4, g4, rdy4}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        v4 = 4'hf;
        @(negedge clk);
        chk("t5_idle", busy4, 0);
        @(negedge clk);
        chk("t5_first", {we4, g4, din4[9:8]}, {1'b1, 4'b0001, 2'd0});
        @(posedge clk); #1;
        v4 = '0;

        // Random run on the 3-requester instance
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sq3[i] = 8'(i * 80);
            sb3[i] = sq3[i];
        end
        drive_d3();
        m_own = -1; m_last = 2; m_cnt = 0;
        run = 0; run_src = 0; max_run = 0;
        rs3 = '0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (rs3[i]) begin
                    sq3[i]++;
                    v3[i] = 1'b0;
                end
                if (!v3[i]) v3[i] = ($urandom_range(0, 9) < 6);
                else if ($urandom_range(0, 15) == 0) v3[i] = 1'b0;
            end
            full3 = ($urandom_range(0, 3) == 0);
            drive_d3();
            @(negedge clk);
            rs3 = rdy3;

            m_we  = (m_own >= 0) && v3[m_own] && !full3;
            m_oh  = (m_own >= 0) ? 3'(3'd1 << m_own) : 3'd0;
            exp_v = {m_we, m_we ? m_oh : 3'd0, m_oh, (m_own >= 0),
                     m_we ? {2'(m_own), d3[m_own*8 +: 8]} : 10'd0};
            obs_v = {we3, rdy3, g3, busy3, we3 ? din3 : 10'd0};
            chk("rnd_cycle", obs_v, exp_v);

            if (we3 && din3[9:8] < 2'd3) begin
                chk("rnd_order", din3[7:0], sb3[din3[9:8]]);
                sb3[din3[9:8]]++;
                if (int'(din3[9:8]) != run_src) begin
                    run_src = int'(din3[9:8]);
                    run = 0;
                end
                run++;
                if (run > max_run) max_run = run;
            end
            if ((v3 & ~(3'd1 << run_src)) == 3'd0) run = 0;

            if (m_own < 0) begin
                m_own = pick3(m_last, v3);
                m_cnt = 0;
            end else begin
                if (m_we) m_cnt++;
                if ((m_we && m_cnt == 4) || !v3[m_own]) begin
                    m_last = m_own;
                    m_own  = pick3(m_last, v3);
                    m_cnt  = 0;
                end
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) if (rs3[i]) sq3[i]++;
        for (int i = 0; i < 3; i++) chk("rnd_count", sb3[i], sq3[i]);
        chk("rnd_burst_cap", (max_run > 4), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bramfifo_wr_arbiter.md
# bramfifo_wr_arbiter

Round-robin write arbiter that shares one block-RAM FIFO write port between `N_` producers. Each producer offers words on a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `BURST_` words and tags every word with the source index. The tagged word drives the FIFO's `we`/`din`, and the arbiter honours the FIFO's `full` flag. It sits directly in front of `bramfifo` and is instantiated wherever several agents feed one buffered stream.

## Interface
- `N_`, 4, number of requesters (2..16)
- `DATA_`, 8, payload width per word
- `BURST_`, 4, maximum consecutive words per grant (1..255)
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  `N_`  per-requester word available
- `req_data`  in  `N_*DATA_`  requester i payload at bits [i*DATA_ +: DATA_]
- `req_ready`  out  `N_`  per-requester word accepted this cycle
- `fifo_full`  in  1  FIFO full flag
- `fifo_we`  out  1  FIFO write enable
- `fifo_din`  out  `DATA_+IDW_`  {source index, payload}; IDW_ = max(1, $clog2(N_))
- `grant`  out  `N_`  one-hot current owner, 0 when idle
- `busy`  out  1  state == GRANT

## Operation
- States: IDLE, GRANT. Registers: `owner` (IDW_), `last` (IDW_), `cnt` (8 bit).
- The round-robin pick searches indices `last+1, last+2, …` modulo `N_` and takes the first one with `req_valid` high.
- IDLE: if any `req_valid` is high, load `owner` with the pick, clear `cnt` and go to GRANT. Otherwise stay in IDLE.
- GRANT: a transfer occurs when `xfer = req_valid[owner] & ~fifo_full`.
  - `fifo_we = xfer`.
  - `req_ready[owner] = xfer`. All other `req_ready` bits are 0.
  - `fifo_din = {owner, req_data[owner]}`.
- On `xfer`, `cnt` increments.
- The burst ends on either of these:
  - `xfer` with `cnt == BURST_-1`.
  - `req_valid[owner]` low.
- At burst end:
  - Set `last <= owner`.
  - Re-pick using the new `last`, evaluated against the current `req_valid`.
  - The just-finished owner is eligible only if no other requester is valid.
  - If the pick succeeds, load `owner`, clear `cnt` and stay in GRANT. There is no bubble.
  - If nothing is valid, go to IDLE.
- `fifo_full` high stalls the burst. `cnt` holds, the grant is kept and the burst does not end.
- Requester ordering within a burst is preserved. The arbiter never drops or duplicates a word.

## Timing
- Reset values:
  - State IDLE, `owner` = 0, `last` = `N_-1` (requester 0 wins first), `cnt` = 0.
  - `fifo_we` = 0, `req_ready` = 0, `grant` = 0, `busy` = 0.
- Reset asserted mid-burst forces these values immediately (asynchronous), without waiting for a clock edge. Any word presented in that cycle is not accepted.
- Latency from IDLE: `req_valid` rises at cycle t, the grant registers at edge t+1, and the first `fifo_we` occurs in cycle t+1.
- `fifo_we`, `req_ready` and `fifo_din` are combinational from the registered state and the inputs. There is no extra pipeline register.
- Back-to-back bursts between different requesters have zero idle cycles.
- `fifo_full` is sampled in the same cycle as the write. `fifo_we` is never high while `fifo_full` is high.
- A producer must hold `req_valid` and `req_data` stable until `req_ready` is high. Dropping valid without a handshake ends its burst.

## Structure
- Package `bramfifo_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT}.
  - function `idw(n)` returning max(1, $clog2(n)).
- Sub-module `rr_pick` (combinational):
  - inputs: `req` [N_], `last`.
  - outputs: `found`, `idx`.
  - The same instance serves both the IDLE pick and the burst-end re-pick.

## Test plan
- Single requester 2 valid for 10 words, `BURST_`=4, FIFO never full:
  - `fifo_we` high for 10 consecutive cycles.
  - Re-arbitration back to requester 2 is seamless.
  - `fifo_din` tag is 2 on all words.
- All 4 requesters valid continuously, `BURST_`=4: grant order 0,1,2,3,0 with exactly 4 words each and no gap cycles.
- `fifo_full` high for 3 cycles in the middle of requester 1's burst:
  - `fifo_we` and `req_ready` are 0 for those cycles.
  - `cnt` holds and requester 1 finishes its remaining words afterwards.
- Requester 3 drops valid after 2 words while requester 0 is valid: in the same cycle the burst ends and requester 0 is granted, with a transfer on the next cycle.
- `rst` asserted asynchronously mid-burst:
  - `fifo_we`, `grant` and `busy` go to 0 before the next edge.
  - After release, requester 0 wins first.
- Scoreboard over 1000 random valid/full cycles, `N_`=3:
  - Per-source word sequences are written to the FIFO in order, with no loss or duplication.
  - No requester ever gets more than `BURST_` consecutive words while others are waiting.
